// File: rtl/m_trap_csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, cause codes, SYSTEM instruction kinds and mstatus bit positions.
package m_trap_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_IRQ_FLAG   = 32'h8000_0000;

    // External interrupt lines occupy mip/mie from this bit upwards
    localparam int unsigned IRQ_BIT_BASE     = 16;
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        SYS_ECALL  = 2'd0,
        SYS_EBREAK = 2'd1,
        SYS_MRET   = 2'd2
    } sys_kind_e;

    // Decoded CSR operation, immediate and register forms collapse together
    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_e;

    // New CSR value for a read-modify-write operation
    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                              logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = src;
            CSR_RS:  res = old_val | src;
            CSR_RC:  res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/m_trap_csr_unit_irq_sync.sv
// Multi-flop synchroniser for the asynchronous, level-sensitive interrupt lines.
module m_trap_csr_unit_irq_sync
    import m_trap_csr_unit_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic [NUM_IRQ-1:0] o_irq_sync
);

    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];

    // Shift each line through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= i_irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_irq_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/m_trap_csr_unit.sv
// Machine-mode CSR file and trap controller. Resolves one event per cycle
// (exception > ECALL/EBREAK > MRET > interrupt > CSR write) and issues a
// single registered redirect to fetch.
module m_trap_csr_unit
    import m_trap_csr_unit_pkg::*;
#(
    parameter int unsigned    XLEN        = 32,
    parameter int unsigned    NUM_IRQ     = 4,
    parameter logic [31:0]    RESET_MTVEC = 32'h4,
    parameter int unsigned    SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_csr_valid,
    input  logic [2:0]         i_csr_op,
    input  logic [11:0]        i_csr_addr,
    input  logic [XLEN-1:0]    i_csr_src,
    input  logic               i_csr_src_zero,
    input  logic               i_sys_valid,
    input  logic [1:0]         i_sys_kind,
    input  logic               i_exc_valid,
    input  logic [3:0]         i_exc_cause,
    input  logic [XLEN-1:0]    i_exc_tval,
    input  logic [XLEN-1:0]    i_pc_ex,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic               o_csr_rd_en,
    output logic [XLEN-1:0]    o_csr_rd_dat,
    output logic               o_csr_illegal,
    output logic               o_trap_take,
    output logic [XLEN-1:0]    o_trap_target,
    output logic               o_trap_is_mret
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("m_trap_csr_unit supports XLEN == 32 only");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
        $error("m_trap_csr_unit supports NUM_IRQ in 1..16");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("m_trap_csr_unit needs SYNC_STAGES >= 1");
    end

    // Architectural state
    logic               r_mst_mie;
    logic               r_mst_mpie;
    logic [NUM_IRQ-1:0] r_mie_irq;
    logic [XLEN-1:0]    r_mtvec;
    logic [XLEN-1:0]    r_mscratch;
    logic [XLEN-1:0]    r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [XLEN-1:0]    r_mtval;
    logic [63:0]        r_mcycle;

    // Output registers
    logic               r_csr_rd_en;
    logic [XLEN-1:0]    r_csr_rd_dat;
    logic               r_csr_illegal;
    logic               r_trap_take;
    logic [XLEN-1:0]    r_trap_target;
    logic               r_trap_is_mret;

    logic [NUM_IRQ-1:0] w_irq_sync;
    logic [XLEN-1:0]    w_mip;
    logic [XLEN-1:0]    w_mie;
    logic [XLEN-1:0]    w_mstatus;
    logic [XLEN-1:0]    w_rdata;
    logic [XLEN-1:0]    w_wdata;
    logic               w_legal;
    csr_op_e            w_op;
    logic               w_op_wr;
    logic               w_csr_we;
    logic [NUM_IRQ-1:0] w_pend;
    logic               w_irq_req;
    logic [3:0]         w_irq_idx;
    logic [4:0]         w_irq_num;
    logic               w_sys_trap;
    logic               w_mret;
    logic               w_irq_take;
    logic               w_trap;
    logic [XLEN-1:0]    w_cause;
    logic [XLEN-1:0]    w_tval;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_target;

    m_trap_csr_unit_irq_sync #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_irq      (i_irq),
        .o_irq_sync (w_irq_sync)
    );

    // CSR read mux and operation decode
    always_comb begin
        w_mip = '0;
        w_mip[IRQ_BIT_BASE +: NUM_IRQ] = w_irq_sync;
        w_mie = '0;
        w_mie[IRQ_BIT_BASE +: NUM_IRQ] = r_mie_irq;
        w_mstatus = '0;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mst_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mst_mpie;

        w_legal = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS:  w_rdata = w_mstatus;
            CSR_MIE:      w_rdata = w_mie;
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MIP:      w_rdata = w_mip;
            CSR_MCYCLE:   w_rdata = r_mcycle[31:0];
            CSR_MCYCLEH:  w_rdata = r_mcycle[63:32];
            default: begin
                w_rdata = '0;
                w_legal = 1'b0;
            end
        endcase

        case (i_csr_op)
            3'd1, 3'd5: w_op = CSR_RW;
            3'd2, 3'd6: w_op = CSR_RS;
            3'd3, 3'd7: w_op = CSR_RC;
            default:    w_op = CSR_NOP;
        endcase
        // Set/clear with a zero source index is a pure read
        w_op_wr = (w_op == CSR_RW) || ((w_op == CSR_RS || w_op == CSR_RC) && !i_csr_src_zero);
        w_wdata = csr_apply(w_op, w_rdata, i_csr_src);
    end

    // Interrupt selection (lowest index wins) and event prioritisation
    always_comb begin
        w_pend    = w_irq_sync & r_mie_irq;
        // No interrupt in the cycle right after a redirect
        w_irq_req = r_mst_mie & (|w_pend) & ~r_trap_take;
        w_irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_irq_idx = 4'(i);
            end
        end
        w_irq_num = 5'(IRQ_BIT_BASE) + {1'b0, w_irq_idx};

        w_sys_trap = i_sys_valid && (i_sys_kind == SYS_ECALL || i_sys_kind == SYS_EBREAK);
        w_mret     = i_sys_valid && (i_sys_kind == SYS_MRET) && !i_exc_valid;
        w_irq_take = w_irq_req && !i_exc_valid && !w_sys_trap && !w_mret;
        w_trap     = i_exc_valid || w_sys_trap || w_irq_take;
        w_csr_we   = i_csr_valid && w_legal && w_op_wr && !w_trap && !w_mret;

        if (i_exc_valid) begin
            w_cause = {{(XLEN-4){1'b0}}, i_exc_cause};
            w_tval  = i_exc_tval;
        end else if (w_sys_trap && i_sys_kind == SYS_ECALL) begin
            w_cause = CAUSE_ECALL_M;
            w_tval  = '0;
        end else if (w_sys_trap) begin
            w_cause = CAUSE_BREAKPOINT;
            w_tval  = i_pc_ex;
        end else begin
            w_cause = CAUSE_IRQ_FLAG | XLEN'(w_irq_num);
            w_tval  = '0;
        end

        w_base = {r_mtvec[XLEN-1:2], 2'b00};
        if (w_irq_take && r_mtvec[1:0] == 2'b01) begin
            w_target = w_base + {{(XLEN-7){1'b0}}, w_irq_num, 2'b00};
        end else begin
            w_target = w_base;
        end
    end

    // CSR state: trap entry and MRET take precedence over software writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mie_irq  <= '0;
            r_mtvec    <= RESET_MTVEC;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (w_trap) begin
            r_mepc     <= {i_pc_ex[XLEN-1:2], 2'b00};
            r_mcause   <= w_cause;
            r_mtval    <= w_tval;
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
        end else if (w_mret) begin
            r_mst_mie  <= r_mst_mpie;
            r_mst_mpie <= 1'b1;
        end else if (w_csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    r_mst_mie  <= w_wdata[MSTATUS_MIE_BIT];
                    r_mst_mpie <= w_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      r_mie_irq  <= w_wdata[IRQ_BIT_BASE +: NUM_IRQ];
                CSR_MTVEC:    r_mtvec    <= w_wdata;
                CSR_MSCRATCH: r_mscratch <= w_wdata;
                CSR_MEPC:     r_mepc     <= {w_wdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   r_mcause   <= w_wdata;
                CSR_MTVAL:    r_mtval    <= w_wdata;
                default: ;
            endcase
        end
    end

    // Free-running cycle counter; a write to either half replaces the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= '0;
        end else if (w_csr_we && i_csr_addr == CSR_MCYCLE) begin
            r_mcycle[31:0] <= w_wdata;
        end else if (w_csr_we && i_csr_addr == CSR_MCYCLEH) begin
            r_mcycle[63:32] <= w_wdata;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // Registered read-back and redirect outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csr_rd_en    <= 1'b0;
            r_csr_rd_dat   <= '0;
            r_csr_illegal  <= 1'b0;
            r_trap_take    <= 1'b0;
            r_trap_target  <= '0;
            r_trap_is_mret <= 1'b0;
        end else begin
            r_csr_rd_en    <= i_csr_valid;
            r_csr_rd_dat   <= i_csr_valid ? w_rdata : '0;
            r_csr_illegal  <= i_csr_valid && !w_legal;
            r_trap_take    <= w_trap || w_mret;
            r_trap_target  <= w_trap ? w_target : (w_mret ? r_mepc : '0);
            r_trap_is_mret <= w_mret;
        end
    end

    assign o_csr_rd_en    = r_csr_rd_en;
    assign o_csr_rd_dat   = r_csr_rd_dat;
    assign o_csr_illegal  = r_csr_illegal;
    assign o_trap_take    = r_trap_take;
    assign o_trap_target  = r_trap_target;
    assign o_trap_is_mret = r_trap_is_mret;

endmodule

// File: tb/tb_m_trap_csr_unit.sv
// Directed bench for m_trap_csr_unit: CSR ops, traps, MRET, interrupts,
// mcycle carry and asynchronous reset.
module tb_m_trap_csr_unit;

    logic        clk;
    logic        rst_n;
    logic        i_csr_valid;
    logic [2:0]  i_csr_op;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_src;
    logic        i_csr_src_zero;
    logic        i_sys_valid;
    logic [1:0]  i_sys_kind;
    logic        i_exc_valid;
    logic [3:0]  i_exc_cause;
    logic [31:0] i_exc_tval;
    logic [31:0] i_pc_ex;
    logic [3:0]  i_irq;
    logic        o_csr_rd_en;
    logic [31:0] o_csr_rd_dat;
    logic        o_csr_illegal;
    logic        o_trap_take;
    logic [31:0] o_trap_target;
    logic        o_trap_is_mret;

    int n_checks = 0;
    int n_errors = 0;

    m_trap_csr_unit #(
        .XLEN        (32),
        .NUM_IRQ     (4),
        .RESET_MTVEC (32'h4),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_csr_valid    (i_csr_valid),
        .i_csr_op       (i_csr_op),
        .i_csr_addr     (i_csr_addr),
        .i_csr_src      (i_csr_src),
        .i_csr_src_zero (i_csr_src_zero),
        .i_sys_valid    (i_sys_valid),
        .i_sys_kind     (i_sys_kind),
        .i_exc_valid    (i_exc_valid),
        .i_exc_cause    (i_exc_cause),
        .i_exc_tval     (i_exc_tval),
        .i_pc_ex        (i_pc_ex),
        .i_irq          (i_irq),
        .o_csr_rd_en    (o_csr_rd_en),
        .o_csr_rd_dat   (o_csr_rd_dat),
        .o_csr_illegal  (o_csr_illegal),
        .o_trap_take    (o_trap_take),
        .o_trap_target  (o_trap_target),
        .o_trap_is_mret (o_trap_is_mret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Clock edge, settle, then drop all one-cycle strobes
    task automatic cyc();
        @(posedge clk);
        #1;
        i_csr_valid    = 1'b0;
        i_csr_src_zero = 1'b0;
        i_sys_valid    = 1'b0;
        i_exc_valid    = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                       input logic zero);
        @(negedge clk);
        i_csr_valid    = 1'b1;
        i_csr_op       = op;
        i_csr_addr     = addr;
        i_csr_src      = src;
        i_csr_src_zero = zero;
        cyc();
    endtask

    // CSRRS with rs1 = x0: pure read
    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        csr(3'd2, addr, 32'h0, 1'b1);
        check(tag, o_csr_rd_dat, exp);
    endtask

    task automatic sys(input logic [1:0] kind, input logic [31:0] pc);
        @(negedge clk);
        i_sys_valid = 1'b1;
        i_sys_kind  = kind;
        i_pc_ex     = pc;
        cyc();
    endtask

    initial begin
        rst_n          = 1'b0;
        i_csr_valid    = 1'b0;
        i_csr_op       = 3'd0;
        i_csr_addr     = 12'h0;
        i_csr_src      = 32'h0;
        i_csr_src_zero = 1'b0;
        i_sys_valid    = 1'b0;
        i_sys_kind     = 2'd0;
        i_exc_valid    = 1'b0;
        i_exc_cause    = 4'd0;
        i_exc_tval     = 32'h0;
        i_pc_ex        = 32'h0;
        i_irq          = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rd_en", {31'h0, o_csr_rd_en}, 32'h0);
        check("reset_take", {31'h0, o_trap_take}, 32'h0);
        check("reset_target", o_trap_target, 32'h0);
        check("reset_rd_dat", o_csr_rd_dat, 32'h0);
        rst_n = 1'b1;
        rd(12'h305, 32'h4, "reset_mtvec");
        rd(12'h300, 32'h0, "reset_mstatus");

        // mcycle low-half write and carry into mcycleh
        csr(3'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        check("mcycle_wr_rd_en", {31'h0, o_csr_rd_en}, 32'h1);
        idle();
        rd(12'hB80, 32'h1, "mcycleh_carry");
        rd(12'hB00, 32'h1, "mcycle_low");

        // ECALL with direct mtvec
        csr(3'd1, 12'h305, 32'h100, 1'b0);
        sys(2'd0, 32'h200);
        check("ecall_take", {31'h0, o_trap_take}, 32'h1);
        check("ecall_target", o_trap_target, 32'h100);
        check("ecall_is_mret", {31'h0, o_trap_is_mret}, 32'h0);
        idle();
        check("ecall_pulse_end", {31'h0, o_trap_take}, 32'h0);
        rd(12'h341, 32'h200, "ecall_mepc");
        rd(12'h342, 32'd11, "ecall_mcause");
        rd(12'h343, 32'h0, "ecall_mtval");

        // Exception beats a simultaneous ECALL
        @(negedge clk);
        i_exc_valid = 1'b1;
        i_exc_cause = 4'd4;
        i_exc_tval  = 32'h1003;
        i_sys_valid = 1'b1;
        i_sys_kind  = 2'd0;
        i_pc_ex     = 32'h204;
        cyc();
        check("exc_take", {31'h0, o_trap_take}, 32'h1);
        check("exc_target", o_trap_target, 32'h100);
        idle();
        check("exc_single_pulse", {31'h0, o_trap_take}, 32'h0);
        rd(12'h342, 32'd4, "exc_mcause");
        rd(12'h343, 32'h1003, "exc_mtval");
        rd(12'h341, 32'h204, "exc_mepc");

        // MRET restores MIE from MPIE
        csr(3'd1, 12'h341, 32'h300, 1'b0);
        csr(3'd1, 12'h300, 32'h80, 1'b0);
        sys(2'd2, 32'h208);
        check("mret_take", {31'h0, o_trap_take}, 32'h1);
        check("mret_target", o_trap_target, 32'h300);
        check("mret_is_mret", {31'h0, o_trap_is_mret}, 32'h1);
        idle();
        rd(12'h300, 32'h88, "mret_mstatus");

        // Set with zero source is read-only; clear shows old value
        csr(3'd2, 12'h300, 32'hFFFF_FFFF, 1'b1);
        check("rs_zero_rd_dat", o_csr_rd_dat, 32'h88);
        rd(12'h300, 32'h88, "rs_zero_unchanged");
        csr(3'd1, 12'h304, 32'h0005_0000, 1'b0);
        csr(3'd3, 12'h304, 32'h0001_0000, 1'b0);
        check("rc_old_value", o_csr_rd_dat, 32'h0005_0000);
        rd(12'h304, 32'h0004_0000, "rc_mie_result");

        // Unimplemented address
        csr(3'd2, 12'h7C0, 32'h5, 1'b0);
        check("illegal_pulse", {31'h0, o_csr_illegal}, 32'h1);
        check("illegal_data", o_csr_rd_dat, 32'h0);
        check("illegal_rd_en", {31'h0, o_csr_rd_en}, 32'h1);
        idle();
        check("illegal_pulse_end", {31'h0, o_csr_illegal}, 32'h0);

        // Vectored interrupt on irq[2]
        csr(3'd1, 12'h305, 32'h1000_0001, 1'b0);
        @(negedge clk);
        i_irq   = 4'b0100;
        i_pc_ex = 32'h400;
        cyc();
        check("irq_sync_1", {31'h0, o_trap_take}, 32'h0);
        idle();
        check("irq_sync_2", {31'h0, o_trap_take}, 32'h0);
        idle();
        check("irq_take", {31'h0, o_trap_take}, 32'h1);
        check("irq_target", o_trap_target, 32'h1000_0048);
        idle();
        check("irq_blackout", {31'h0, o_trap_take}, 32'h0);
        rd(12'h344, 32'h0004_0000, "irq_mip");
        rd(12'h342, 32'h8000_0012, "irq_mcause");
        rd(12'h300, 32'h80, "irq_mstatus");
        rd(12'h341, 32'h400, "irq_mepc");
        i_irq = 4'h0;

        // Asynchronous reset while a redirect is being presented
        sys(2'd0, 32'h500);
        check("pre_reset_take", {31'h0, o_trap_take}, 32'h1);
        check("pre_reset_target", o_trap_target, 32'h1000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_take", {31'h0, o_trap_take}, 32'h0);
        check("async_reset_target", o_trap_target, 32'h0);
        check("async_reset_rd_en", {31'h0, o_csr_rd_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("post_reset_no_pulse", {31'h0, o_trap_take}, 32'h0);
        rd(12'h305, 32'h4, "post_reset_mtvec");
        rd(12'h342, 32'h0, "post_reset_mcause");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/m_trap_csr_unit.md
Name: m_trap_csr_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the single-hart core; sits in EX stage beside the ALU.
- Supports CSRRW/RS/RC and immediate forms, prioritised synchronous exceptions, ECALL/EBREAK/MRET, NUM_IRQ external interrupt lines with mie/mip masking, MIE/MPIE stacking, vectored mtvec and a 64-bit mcycle counter.
- Drives a single registered redirect (trap_take/trap_target) to the fetch stage.

Parameters:
- XLEN, 32, data width (only 32 supported; checked at elaboration).
- NUM_IRQ, 4, external interrupt lines, mapped to mip/mie bits 16..16+NUM_IRQ-1 (1..16).
- RESET_MTVEC, 32'h4, mtvec reset value.
- SYNC_STAGES, 2, irq synchroniser depth (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- csr_valid  in  1  CSR instruction in EX this cycle.
- csr_op  in  3  funct3: 1/2/3 = RW/RS/RC; 5/6/7 = immediate forms.
- csr_addr  in  12  CSR address.
- csr_src  in  XLEN  forwarded rs1 value, or zero-extended zimm (selected upstream).
- csr_src_zero  in  1  rs1 index / zimm is 0; suppresses writes for RS/RC.
- sys_valid  in  1  SYSTEM non-CSR instruction.
- sys_kind  in  2  0 = ECALL, 1 = EBREAK, 2 = MRET.
- exc_valid  in  1  synchronous exception (misaligned fetch/load/store).
- exc_cause  in  4  exception code 0, 4 or 6.
- exc_tval  in  XLEN  faulting address.
- pc_ex  in  XLEN  PC of the EX instruction.
- irq  in  NUM_IRQ  asynchronous, level-sensitive interrupt lines.
- csr_rd_en  out  1  registered; rd writeback strobe.
- csr_rd_dat  out  XLEN  registered; old CSR value.
- csr_illegal  out  1  registered; one-cycle pulse on an unimplemented address.
- trap_take  out  1  registered; one-cycle redirect pulse.
- trap_target  out  XLEN  valid while trap_take is high.
- trap_is_mret  out  1  qualifies trap_take.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: all outputs 0; mstatus 0, mie 0, mepc 0, mcause 0, mtval 0, mscratch 0, mcycle 0, mtvec RESET_MTVEC, synchroniser 0.
- Latency: every output is registered; it appears the cycle after the qualifying input.
- Implemented CSRs: mstatus 300 (MIE bit 3, MPIE bit 7; other bits read 0), mie 304, mtvec 305, mscratch 340, mepc 341 (bits 1:0 read 0), mcause 342, mtval 343, mip 344 (read-only), mcycle B00, mcycleh B80.
- CSR op:
  - RW writes csr_src.
  - RS writes old | src; RC writes old & ~src.
  - RS/RC write nothing when csr_src_zero is set.
  - csr_rd_en=1 for every csr_valid; csr_rd_dat = value before the write.
- Unknown address: csr_rd_dat 0, no write, csr_illegal pulses, csr_rd_en still 1.
- mip[16+i] = synchronised irq[i], after SYNC_STAGES flops.
- Interrupt request: mstatus.MIE & |(mip & mie) & ~trap_take. The ~trap_take term gives a one-cycle blackout after any redirect. The lowest index wins.
- Event priority, one event per cycle: exc_valid > ECALL/EBREAK > MRET > interrupt > CSR write.
  - A trap or MRET in the same cycle drops the CSR write; csr_rd_en still follows csr_valid.
- Trap entry (next edge):
  - mepc<=pc_ex, mcause<=code, MPIE<=MIE, MIE<=0.
  - trap_take=1, trap_is_mret=0.
  - Codes: ECALL 11, EBREAK 3, exc_cause; interrupt = 0x8000_0000 | (16+i).
  - mtval: exc_tval for exceptions, pc_ex for EBREAK, 0 otherwise.
- Target: {mtvec[31:2],2'b00}. If mtvec[1:0]==1 and the event is an interrupt, target = base + 4*(16+i).
- MRET: MIE<=MPIE, MPIE<=1, trap_target=mepc, trap_is_mret=1.
- mcycle: 64-bit, increments every cycle.
  - A CSR write to either half replaces that half and suppresses the increment that cycle.
  - Carry from the low half wraps into mcycleh.
  - Reads return the pre-increment value.
- Reset mid-operation clears pending redirects immediately; no pulse follows reset release.

Decomposition:
- Shared package (csr_pkg): CSR address constants, cause codes, sys_kind encodings, MIE/MPIE bit positions.
- One natural sub-module: irq_sync (parametrised NUM_IRQ x SYNC_STAGES flop chain).

Test Plan:
- Write 0x1000_0001 to mtvec; raise irq[2] with mie[18]=1, MIE=1 after sync -> trap_target 0x1000_0048, mcause 0x8000_0012, MIE=0, MPIE=1.
- ECALL at pc_ex 0x200 with mtvec 0x100 -> trap_take 1 cycle, target 0x100, mepc 0x200, mcause 11, mtval 0.
- exc_valid(cause 4, tval 0x1003) and ECALL in the same cycle -> mcause 4, mtval 0x1003, single pulse.
- Set mepc 0x300, MPIE=1, then MRET -> target 0x300, trap_is_mret 1, MIE=1.
- CSRRS mstatus with csr_src_zero=1 -> mstatus unchanged; CSRRC mie 0x10000 -> bit 16 cleared, csr_rd_dat shows old value; read of 0x7C0 -> csr_illegal pulse, data 0.
- Write mcycle 0xFFFF_FFFF -> after 2 cycles mcycleh = 1, mcycle = 1; assert rst_n low mid-trap -> all outputs 0 asynchronously.
